// File: rtl/pipe_stage_reg.sv
// Two-entry (main + skid) valid/ready pipeline register with registered in_ready and flush.
// Optional stall counter is compiled in when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg #(
  parameter int DATA_W = 16,
  parameter int NWORDS = 5,
  parameter int FLAG_W = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NWORDS*DATA_W-1:0] in_data,
  input  logic [FLAG_W-1:0]        in_flags,
  input  logic                     in_wr_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NWORDS*DATA_W-1:0] out_data,
  output logic [FLAG_W-1:0]        out_flags,
  output logic                     out_wr_en,
  input  logic                     flush,
  output logic [1:0]               occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [15:0]              stall_cnt
`endif
);

  localparam int PW = NWORDS * DATA_W;

  logic          main_valid_q, main_valid_d;
  logic          skid_valid_q, skid_valid_d;
  logic [PW-1:0] main_data_q, main_data_d;
  logic [PW-1:0] skid_data_q, skid_data_d;
  logic [FLAG_W-1:0] main_flags_q, main_flags_d;
  logic [FLAG_W-1:0] skid_flags_q, skid_flags_d;
  logic          main_wr_q, main_wr_d;
  logic          skid_wr_q, skid_wr_d;
  logic          push, pop;

  // in_ready comes straight from the skid-valid flop, so it never sees out_ready.
  assign in_ready = ~skid_valid_q;
  assign push     = in_valid & ~skid_valid_q;
  assign pop      = main_valid_q & out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_data_d  = main_data_q;
    main_flags_d = main_flags_q;
    main_wr_d    = main_wr_q;
    skid_data_d  = skid_data_q;
    skid_flags_d = skid_flags_q;
    skid_wr_d    = skid_wr_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      if (pop) begin
        main_data_d  = skid_data_q;
        main_flags_d = skid_flags_q;
        main_wr_d    = skid_wr_q;
        skid_valid_d = 1'b0;
      end
    end else if (main_valid_q) begin
      if (push && pop) begin
        main_data_d  = in_data;
        main_flags_d = in_flags;
        main_wr_d    = in_wr_en;
      end else if (push) begin
        skid_data_d  = in_data;
        skid_flags_d = in_flags;
        skid_wr_d    = in_wr_en;
        skid_valid_d = 1'b1;
      end else if (pop) begin
        main_valid_d = 1'b0;
      end
    end else if (push) begin
      main_data_d  = in_data;
      main_flags_d = in_flags;
      main_wr_d    = in_wr_en;
      main_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_flags_q <= '0;
      main_wr_q    <= 1'b0;
      skid_data_q  <= '0;
      skid_flags_q <= '0;
      skid_wr_q    <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      main_flags_q <= main_flags_d;
      main_wr_q    <= main_wr_d;
      skid_data_q  <= skid_data_d;
      skid_flags_q <= skid_flags_d;
      skid_wr_q    <= skid_wr_d;
    end
  end

  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign out_flags = main_flags_q;
  assign out_wr_en = main_wr_q & main_valid_q;
  assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

`ifdef PIPE_STAGE_PERF_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (flush) begin
      stall_d = '0;
    end else if (main_valid_q && !out_ready && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed test of pipe_stage_reg: ordering, skid, flush, async reset, optional stall counter.
module tb_pipe_stage_reg;
  localparam int DATA_W = 16;
  localparam int NWORDS = 5;
  localparam int FLAG_W = 2;
  localparam int PW = NWORDS * DATA_W;

  logic          clk, rst;
  logic          in_valid, in_ready;
  logic [PW-1:0] in_data;
  logic [FLAG_W-1:0] in_flags;
  logic          in_wr_en;
  logic          out_valid, out_ready;
  logic [PW-1:0] out_data;
  logic [FLAG_W-1:0] out_flags;
  logic          out_wr_en, flush;
  logic [1:0]    occupancy;
`ifdef PIPE_STAGE_PERF_EN
  logic [15:0]   stall_cnt;
`endif

  int total  = 0;
  int passed = 0;
  int failed = 0;

  pipe_stage_reg #(.DATA_W(DATA_W), .NWORDS(NWORDS), .FLAG_W(FLAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_flags(in_flags), .in_wr_en(in_wr_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_flags(out_flags), .out_wr_en(out_wr_en),
    .flush(flush), .occupancy(occupancy)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Payload words: [4]=mem, [3]=alu, [2]=IR, [1]=pc2, [0]=pc
  function automatic logic [PW-1:0] mk(input logic [15:0] w);
    return {w ^ 16'h00F0, w + 16'd3, w, w + 16'd1, ~w};
  endfunction

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
      $display("check %s: observed %0h expected %0h", tag, obs, exp);
    end else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] w, input logic [1:0] f, input logic we);
    in_valid = v;
    in_data  = mk(w);
    in_flags = f;
    in_wr_en = we;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_flags = '0; in_wr_en = 1'b0;
    out_ready = 1'b0; flush = 1'b0;
    #2;
    chk("rst_out_valid", PW'(out_valid), PW'(0));
    chk("rst_occ", PW'(occupancy), PW'(0));
    chk("rst_in_ready", PW'(in_ready), PW'(1));
    chk("rst_out_data", out_data, '0);
    step(); step();
    rst = 1'b1;
    step();
    chk("rel_in_ready", PW'(in_ready), PW'(1));
    chk("rel_out_valid", PW'(out_valid), PW'(0));

    // Single push reaches output after one edge
    out_ready = 1'b1;
    drive(1'b1, 16'h1234, 2'b01, 1'b1);
    step();
    chk("t1_valid", PW'(out_valid), PW'(1));
    chk("t1_ir", PW'(out_data[2*DATA_W +: DATA_W]), PW'(16'h1234));
    chk("t1_data", out_data, mk(16'h1234));
    chk("t1_flags", PW'(out_flags), PW'(2'b01));
    chk("t1_wr", PW'(out_wr_en), PW'(1));
    chk("t1_occ", PW'(occupancy), PW'(1));

    // Streaming push+pop replaces main, occupancy stays 1
    drive(1'b1, 16'h5555, 2'b10, 1'b0);
    step();
    chk("str_data", out_data, mk(16'h5555));
    chk("str_flags", PW'(out_flags), PW'(2'b10));
    chk("str_wr", PW'(out_wr_en), PW'(0));
    chk("str_occ", PW'(occupancy), PW'(1));
    drive(1'b1, 16'h7777, 2'b11, 1'b1);
    step();
    chk("str2_data", out_data, mk(16'h7777));
    chk("str2_wr", PW'(out_wr_en), PW'(1));
    in_valid = 1'b0;
    step();
    chk("bub_valid", PW'(out_valid), PW'(0));
    chk("bub_wr", PW'(out_wr_en), PW'(0));
    chk("bub_occ", PW'(occupancy), PW'(0));

    // Skid fill with backpressure, then drain in order
    out_ready = 1'b0;
    drive(1'b1, 16'h0001, 2'b01, 1'b1);
    step();
    chk("sk_occ1", PW'(occupancy), PW'(1));
    drive(1'b1, 16'h0002, 2'b10, 1'b0);
    step();
    chk("sk_occ2", PW'(occupancy), PW'(2));
    chk("sk_in_ready", PW'(in_ready), PW'(0));
    chk("sk_holdA", out_data, mk(16'h0001));
    drive(1'b1, 16'h0009, 2'b11, 1'b1);
    step();
    chk("sk_occ_blk", PW'(occupancy), PW'(2));
    chk("sk_holdA2", out_data, mk(16'h0001));
    chk("sk_hold_flags", PW'(out_flags), PW'(2'b01));
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("sk_popB", out_data, mk(16'h0002));
    chk("sk_popB_wr", PW'(out_wr_en), PW'(0));
    chk("sk_occ_after", PW'(occupancy), PW'(1));
    chk("sk_in_ready1", PW'(in_ready), PW'(1));
    step();
    chk("sk_empty", PW'(out_valid), PW'(0));
    chk("sk_empty_occ", PW'(occupancy), PW'(0));

    // Flush at occupancy 2 with a simultaneous push
    out_ready = 1'b0;
    drive(1'b1, 16'h0001, 2'b01, 1'b1);
    step();
    drive(1'b1, 16'h0002, 2'b01, 1'b1);
    step();
    chk("fl_occ2", PW'(occupancy), PW'(2));
    drive(1'b1, 16'h0003, 2'b11, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", PW'(out_valid), PW'(0));
    chk("fl_occ", PW'(occupancy), PW'(0));
    chk("fl_in_ready", PW'(in_ready), PW'(1));
    chk("fl_wr", PW'(out_wr_en), PW'(0));
    out_ready = 1'b1;
    step();
    chk("fl_noC", PW'(out_valid), PW'(0));

    // Asynchronous reset mid-cycle at occupancy 2
    out_ready = 1'b0;
    drive(1'b1, 16'h0004, 2'b01, 1'b1);
    step();
    drive(1'b1, 16'h0005, 2'b10, 1'b1);
    step();
    in_valid = 1'b0;
    chk("ar_occ2", PW'(occupancy), PW'(2));
    #2 rst = 1'b0;
    #1;
    chk("ar_valid", PW'(out_valid), PW'(0));
    chk("ar_data", out_data, '0);
    chk("ar_flags", PW'(out_flags), PW'(0));
    chk("ar_wr", PW'(out_wr_en), PW'(0));
    chk("ar_occ", PW'(occupancy), PW'(0));
    chk("ar_in_ready", PW'(in_ready), PW'(1));
    #2 rst = 1'b1;
    step();
    chk("ar_rel_in_ready", PW'(in_ready), PW'(1));
    out_ready = 1'b1;
    drive(1'b1, 16'hBEEF, 2'b01, 1'b1);
    step();
    in_valid = 1'b0;
    chk("ar_beef_valid", PW'(out_valid), PW'(1));
    chk("ar_beef_ir", PW'(out_data[2*DATA_W +: DATA_W]), PW'(16'hBEEF));
    chk("ar_beef_occ", PW'(occupancy), PW'(1));

`ifdef PIPE_STAGE_PERF_EN
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("pf_clear0", PW'(stall_cnt), PW'(0));
    out_ready = 1'b0;
    drive(1'b1, 16'h0006, 2'b00, 1'b0);
    step();
    in_valid = 1'b0;
    chk("pf_start", PW'(stall_cnt), PW'(0));
    for (int i = 0; i < 5; i++) step();
    chk("pf_five", PW'(stall_cnt), PW'(5));
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("pf_flush", PW'(stall_cnt), PW'(0));
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 16, width of one payload word.
REQ-002 Parameter NWORDS, default 5, payload words per beat (pc, pc2, IR, alu result, mem read value).
REQ-003 Parameter FLAG_W, default 2, status flag bits per beat (carry, zero).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 in_valid  in  1  upstream beat present.
REQ-007 in_ready  out  1  stage can accept a beat this cycle.
REQ-008 in_data  in  NWORDS*DATA_W  payload; word k at bits [k*DATA_W +: DATA_W].
REQ-009 in_flags  in  FLAG_W  status flags.
REQ-010 in_wr_en  in  1  register-write enable carried with the beat.
REQ-011 out_valid  out  1  beat present at output.
REQ-012 out_ready  in  1  downstream accepts the output beat.
REQ-013 out_data / out_flags / out_wr_en  out  NWORDS*DATA_W / FLAG_W / 1  registered copies of the accepted beat.
REQ-014 flush  in  1  synchronous kill of all held beats.
REQ-015 occupancy  out  2  beats held, 0..2.
REQ-016 stall_cnt  out  16  cycles with out_valid=1 and out_ready=0 (present only with PIPE_STAGE_PERF_EN).

Function
REQ-017 Push occurs when in_valid=1 and in_ready=1; pop occurs when out_valid=1 and out_ready=1.
REQ-018 Storage is two entries, main and skid; output always presents main.
REQ-019 Latency: a beat pushed at edge N is on out_* after edge N if main was empty or popped at N.
REQ-020 in_ready is a registered signal equal to NOT skid-valid; it never depends combinationally on out_ready.
REQ-021 Occupancy 0, push: beat enters main; occupancy becomes 1.
REQ-022 Occupancy 1, push and pop: new beat replaces main; occupancy stays 1.
REQ-023 Occupancy 1, push without pop: beat enters skid; occupancy becomes 2; in_ready goes 0.
REQ-024 Occupancy 2, pop: skid moves to main; occupancy becomes 1; in_ready goes 1; no push is possible in this state.
REQ-025 Beats leave in arrival order; no beat is duplicated or dropped except by flush.
REQ-026 While out_valid=1 and out_ready=0, out_data, out_flags and out_wr_en hold stable.
REQ-027 out_wr_en = stored wr_en AND out_valid; a bubble never asserts out_wr_en.
REQ-028 flush=1 at an edge: both entries invalid, occupancy 0, in_ready 1; a simultaneous push is discarded.
REQ-029 flush has priority over push and pop in the same cycle; payload registers keep their old values but are masked by out_valid=0.

Reset
REQ-030 rst low immediately forces out_valid=0, out_wr_en=0, out_data=0, out_flags=0, occupancy=0, skid cleared, stall_cnt=0, independent of clk.
REQ-031 in_ready is 1 during reset and on the first edge after rst deasserts.
REQ-032 rst asserted mid-transfer discards all held beats; the first push after release enters main with occupancy 1.

Configuration
REQ-033 Macro PIPE_STAGE_PERF_EN, when defined, includes stall_cnt: increments by 1 on each edge with out_valid=1 and out_ready=0, saturates at 16'hFFFF, and clears on flush or reset.
REQ-034 Without PIPE_STAGE_PERF_EN, the stall_cnt port and its counter are absent; all other behaviour is identical.

Verification
REQ-035 Reset release, out_ready=1, push IR=16'h1234 flags=2'b01 wr_en=1 -> next cycle out_valid=1, out_data IR word=16'h1234, out_flags=2'b01, out_wr_en=1, occupancy=1.
REQ-036 out_ready=0, push beats A=16'h0001 then B=16'h0002 -> occupancy=2, in_ready=0, out holds A; raise out_ready -> A then B, one per cycle, in_ready=1 after the first pop.
REQ-037 Occupancy 2, assert flush with in_valid=1 (C=16'h0003) -> next cycle out_valid=0, occupancy=0, in_ready=1; C never appears at the output.
REQ-038 Push beat with wr_en=1, pop it, then no push -> out_valid=0 and out_wr_en=0 the following cycle.
REQ-039 Drive rst low asynchronously between edges while occupancy=2 -> outputs zero at once; after release the first push of 16'hBEEF reaches the output with occupancy 1.
REQ-040 PIPE_STAGE_PERF_EN defined, out_valid=1 held with out_ready=0 for 5 cycles -> stall_cnt=5; flush -> stall_cnt=0.
